// File: rtl/demux1x4_stripe_ctrl.sv
// demux1x4_stripe_ctrl: round-robin 1:4 byte striper for the PCIe TX lane demux.
// Define STRIPE_CTRL_STATS_EN to add the byte_cnt/drop_cnt statistics outputs.
module demux1x4_stripe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  input  logic [3:0]  lane_en,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic [7:0]  data_out2,
  output logic [7:0]  data_out3,
  output logic        valid_out0,
  output logic        valid_out1,
  output logic        valid_out2,
  output logic        valid_out3,
  output logic        stripe_open,
`ifdef STRIPE_CTRL_STATS_EN
  output logic [15:0] byte_cnt,
  output logic [15:0] drop_cnt,
`endif
  output logic        drop_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] mask_r;
  logic [3:0] mask_nxt_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [1:0] lane_s;
  logic       accept_s;
  logic       drop_s;
  logic [3:0] lane_hit_s;

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    casez (m)
      4'b???1: first_lane = 2'd0;
      4'b??10: first_lane = 2'd1;
      4'b?100: first_lane = 2'd2;
      4'b1000: first_lane = 2'd3;
      default: first_lane = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_lane(input logic [3:0] m);
    casez (m)
      4'b1???: last_lane = 2'd3;
      4'b01??: last_lane = 2'd2;
      4'b001?: last_lane = 2'd1;
      default: last_lane = 2'd0;
    endcase
  endfunction

  // Lowest enabled lane above p, wrapping back to the first enabled lane.
  function automatic logic [1:0] next_lane(input logic [1:0] p, input logic [3:0] m);
    logic [3:0] above;
    above = m & (4'b1110 << p);
    if (above != 4'h0) begin
      next_lane = first_lane(above);
    end else begin
      next_lane = first_lane(m);
    end
  endfunction

  function automatic logic single_lane(input logic [3:0] m);
    single_lane = (m != 4'h0) && ((m & (m - 4'd1)) == 4'h0);
  endfunction

  // Next-state and lane-select decode.
  always_comb begin
    state_nxt_s = state_r;
    mask_nxt_s  = mask_r;
    ptr_nxt_s   = ptr_r;
    lane_s      = ptr_r;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        mask_nxt_s = lane_en;
        lane_s     = first_lane(lane_en);
        ptr_nxt_s  = first_lane(lane_en);
        if (valid_in) begin
          if (lane_en == 4'h0) begin
            drop_s = 1'b1;
          end else begin
            accept_s = 1'b1;
            if (single_lane(lane_en)) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = ACTIVE;
              ptr_nxt_s   = next_lane(first_lane(lane_en), lane_en);
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        lane_s = ptr_r;
        if (valid_in) begin
          accept_s = 1'b1;
          if (ptr_r == last_lane(mask_r)) begin
            state_nxt_s = IDLE;
          end else begin
            ptr_nxt_s = next_lane(ptr_r, mask_r);
          end
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    lane_hit_s = accept_s ? (4'b0001 << lane_s) : 4'b0000;
  end

  // State, lane output and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      mask_r      <= lane_en;
      data_out0   <= 8'h00;
      data_out1   <= 8'h00;
      data_out2   <= 8'h00;
      data_out3   <= 8'h00;
      valid_out0  <= 1'b0;
      valid_out1  <= 1'b0;
      valid_out2  <= 1'b0;
      valid_out3  <= 1'b0;
      stripe_open <= 1'b0;
      drop_err    <= 1'b0;
`ifdef STRIPE_CTRL_STATS_EN
      byte_cnt    <= 16'h0000;
      drop_cnt    <= 16'h0000;
`endif
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      mask_r      <= mask_nxt_s;
      valid_out0  <= lane_hit_s[0];
      valid_out1  <= lane_hit_s[1];
      valid_out2  <= lane_hit_s[2];
      valid_out3  <= lane_hit_s[3];
      if (lane_hit_s[0]) data_out0 <= data_in;
      if (lane_hit_s[1]) data_out1 <= data_in;
      if (lane_hit_s[2]) data_out2 <= data_in;
      if (lane_hit_s[3]) data_out3 <= data_in;
      stripe_open <= (state_nxt_s == ACTIVE);
      drop_err    <= drop_s;
`ifdef STRIPE_CTRL_STATS_EN
      byte_cnt    <= byte_cnt + {15'd0, accept_s};
      drop_cnt    <= drop_cnt + {15'd0, drop_s};
`endif
    end
  end

endmodule

// File: tb/tb_demux1x4_stripe_ctrl.sv
// Scoreboard bench for demux1x4_stripe_ctrl: directed plan plus random traffic
// against a lane-list reference model (STRIPE_CTRL_STATS_EN checks counters too).
module tb_demux1x4_stripe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [3:0]  lane_en;
  logic [7:0]  data_out0, data_out1, data_out2, data_out3;
  logic        valid_out0, valid_out1, valid_out2, valid_out3;
  logic        stripe_open;
  logic        drop_err;
`ifdef STRIPE_CTRL_STATS_EN
  logic [15:0] byte_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  demux1x4_stripe_ctrl dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .lane_en(lane_en),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3),
    .stripe_open(stripe_open),
`ifdef STRIPE_CTRL_STATS_EN
    .byte_cnt(byte_cnt), .drop_cnt(drop_cnt),
`endif
    .drop_err(drop_err)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        open;
    logic        drop;
    logic [15:0] bc;
    logic [15:0] dc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: a stripe is the ascending list of enabled lanes, walked by position.
  bit          m_active = 1'b0;
  int          m_list[4];
  int          m_len = 0;
  int          m_pos = 0;
  logic [3:0][7:0] m_data = '0;
  logic [15:0] m_bc = 16'h0000;
  logic [15:0] m_dc = 16'h0000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] d, input logic [3:0] en);
    exp_t e;
    e.vld  = 4'b0000;
    e.drop = 1'b0;
    if (!r) begin
      m_active = 1'b0;
      m_data   = '0;
      m_bc     = 16'h0000;
      m_dc     = 16'h0000;
    end else begin
      if (!m_active) begin
        m_len = 0;
        for (int i = 0; i < 4; i++) if (en[i]) begin m_list[m_len] = i; m_len++; end
        m_pos = 0;
      end
      if (v) begin
        if (m_len == 0) begin
          e.drop = 1'b1;
          m_dc++;
        end else begin
          m_data[m_list[m_pos]] = d;
          e.vld[m_list[m_pos]]  = 1'b1;
          m_pos++;
          m_bc++;
          m_active = (m_pos < m_len);
        end
      end
    end
    e.dat  = m_data;
    e.open = m_active;
    e.bc   = m_bc;
    e.dc   = m_dc;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic [3:0] en);
    @(negedge clk);
    reset    = r;
    valid_in = v;
    data_in  = d;
    lane_en  = en;
    model(r, v, d, en);
  endtask

  // Monitor: compare each registered response against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("valid_out", {28'd0, valid_out3, valid_out2, valid_out1, valid_out0}, {28'd0, e.vld});
        check("data_out", {data_out3, data_out2, data_out1, data_out0}, e.dat);
        check("stripe_open", {31'd0, stripe_open}, {31'd0, e.open});
        check("drop_err", {31'd0, drop_err}, {31'd0, e.drop});
`ifdef STRIPE_CTRL_STATS_EN
        check("byte_cnt", {16'd0, byte_cnt}, {16'd0, e.bc});
        check("drop_cnt", {16'd0, drop_cnt}, {16'd0, e.dc});
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; data_in = 8'h00; lane_en = 4'hF;
    cyc(1'b0, 1'b0, 8'h00, 4'hF);
    cyc(1'b0, 1'b0, 8'h00, 4'hF);
    // full mask
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'h10 + 8'(i), 4'hF);
    cyc(1'b1, 1'b0, 8'h00, 4'hF);
    // sparse mask with a gap
    cyc(1'b1, 1'b1, 8'hA0, 4'b1010);
    cyc(1'b1, 1'b0, 8'h00, 4'b1010);
    cyc(1'b1, 1'b0, 8'h00, 4'b1010);
    cyc(1'b1, 1'b1, 8'hA1, 4'b1010);
    cyc(1'b1, 1'b0, 8'h00, 4'b1010);
    // mask change mid-stripe
    cyc(1'b1, 1'b1, 8'hB0, 4'hF);
    cyc(1'b1, 1'b1, 8'hB1, 4'hF);
    cyc(1'b1, 1'b1, 8'hB2, 4'h1);
    cyc(1'b1, 1'b1, 8'hB3, 4'h1);
    cyc(1'b1, 1'b1, 8'hB4, 4'h1);
    cyc(1'b1, 1'b1, 8'hB5, 4'h1);
    // zero mask
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'hD0 + 8'(i), 4'h0);
    cyc(1'b1, 1'b0, 8'h00, 4'h0);
    // reset mid-stripe
    cyc(1'b1, 1'b1, 8'hC0, 4'hF);
    cyc(1'b1, 1'b1, 8'hC1, 4'hF);
    cyc(1'b0, 1'b0, 8'h00, 4'hF);
    cyc(1'b1, 1'b1, 8'hC2, 4'hF);
    cyc(1'b1, 1'b0, 8'h00, 4'hF);
    // random traffic with live mask changes and occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
          8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end
`ifdef STRIPE_CTRL_STATS_EN
    // counter wrap
    cyc(1'b0, 1'b0, 8'h00, 4'hF);
    for (int i = 0; i < 65537; i++) cyc(1'b1, 1'b1, 8'(i), 4'hF);
`endif
    cyc(1'b1, 1'b0, 8'h00, 4'hF);
    cyc(1'b1, 1'b0, 8'h00, 4'hF);
    @(posedge clk);
    #2;
    check("drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1x4_stripe_ctrl.md
# demux1x4_stripe_ctrl

Byte-striping controller for the 1:4 demultiplexer of the PCIe physical-layer transmit path. Accepts one 8-bit byte plus valid per cycle and steers each valid byte, round-robin, to the next enabled lane out of four. Each lane has a registered 8-bit data and valid output. A lane-enable mask is applied only at stripe boundaries, so a stripe is never split across mask configurations.

## Interface
- No parameters: widths are fixed at 8 data bits and 4 lanes.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  8  input byte.
- valid_in  in  1  data_in holds a byte to stripe this cycle.
- lane_en  in  4  requested lane-enable mask; bit n enables lane n.
- data_out0..data_out3  out  8 each  per-lane registered byte.
- valid_out0..valid_out3  out  1 each  per-lane registered valid.
- stripe_open  out  1  high while a stripe is partially sent (state ACTIVE).
- drop_err  out  1  one-cycle pulse when a valid byte is dropped because the active mask is 0.

## Operation
- Internal state:
  - mask_q[3:0]: active mask.
  - ptr[1:0]: next lane to receive a byte.
  - state: IDLE or ACTIVE.
- Definitions:
  - first(m) = lowest set bit index of m.
  - last(m) = highest set bit index of m.
  - next(p,m) = the lowest set bit above p; if none, first(m).
- Reset (reset==0 at a rising edge):
  - all data_out* = 8'h00, valid_out* = 0, stripe_open = 0, drop_err = 0.
  - state = IDLE, ptr = 0, mask_q = lane_en (sampled that edge).
- IDLE:
  - Every cycle: mask_q <= lane_en; ptr <= first(lane_en), or 0 if lane_en==0.
  - On valid_in: the byte goes to lane first(lane_en), using the live lane_en that cycle.
  - If lane_en has one bit set, stay IDLE (the stripe completes immediately). Otherwise go to ACTIVE with ptr <= next(first,lane_en) and mask_q <= lane_en.
- ACTIVE:
  - mask_q frozen; lane_en changes are ignored.
  - On valid_in: the byte goes to lane ptr.
    - If ptr==last(mask_q), go to IDLE.
    - Otherwise ptr <= next(ptr,mask_q).
  - valid_in low: hold ptr and state. Gaps inside a stripe are legal.
- Zero mask:
  - A valid byte in IDLE with lane_en==0 is not written to any lane. drop_err pulses and state stays IDLE.
  - ACTIVE is never entered with a zero mask.
- Lane outputs:
  - Only the selected lane's data_out is updated, with valid_out=1.
  - All other lanes keep their data_out and have valid_out=0.
  - valid_out* is 0 on every cycle with no accepted byte.
- At most one valid_out is high per cycle.

## Timing
- Latency is 1 cycle: a byte sampled at edge k appears on data_out/valid_out after edge k.
- Throughput is one byte per cycle with no back-pressure.
- stripe_open equals (state==ACTIVE) and is registered.
- drop_err is registered, 1-cycle latency, one pulse per dropped byte.
- Reset mid-stripe: the next edge with reset==0 abandons the stripe. Outputs clear; the bytes already emitted are not re-sent.
- Change of lane_en in the same cycle as the final byte of a stripe: the new mask loads on the following IDLE cycle. The final byte uses the old mask_q.
- Back-to-back stripes: the cycle after the final byte is IDLE and may accept a byte using the current lane_en. There are no bubbles.

## Configuration
- STRIPE_CTRL_STATS_EN defined adds two outputs:
  - byte_cnt[15:0]: counts bytes delivered to lanes.
  - drop_cnt[15:0]: counts dropped bytes.
  - Both reset to 0, increment on the same edge the byte is accepted or dropped, and wrap 16'hFFFF -> 16'h0000.
- STRIPE_CTRL_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Full mask: reset, lane_en=4'hF, send bytes 8'h10..8'h17 on consecutive cycles -> lanes 0,1,2,3,0,1,2,3, each one cycle later; stripe_open high on cycles after bytes 0-2 and 4-6, low after bytes 3 and 7.
- Sparse mask with a gap: lane_en=4'b1010, send 8'hA0, idle 2 cycles, 8'hA1 -> 8'hA0 on lane 1 and 8'hA1 on lane 3; stripe_open stays high through the gap.
- Mask change mid-stripe: lane_en=4'hF, send 2 bytes, set lane_en=4'h1, send 2 more -> bytes go to lanes 0,1,2,3; subsequent bytes all go to lane 0 with stripe_open low.
- Zero mask: lane_en=0, send 3 valid bytes -> no valid_out asserted, drop_err pulses 3 times; with STRIPE_CTRL_STATS_EN, drop_cnt=3 and byte_cnt=0.
- Reset mid-stripe: lane_en=4'hF, send 2 bytes, assert reset for 1 cycle -> all outputs 0 and stripe_open 0; the next byte goes to lane 0.
- Stats wrap (STRIPE_CTRL_STATS_EN): deliver 65537 bytes -> byte_cnt=1.
